// File: rtl/cc_pkg.sv
// Shared constants and types for the skin-region connected-component labeler
// (first pass and merge/second scan).
package cc_pkg;
   localparam int IMG_W  = 320;
   localparam int IMG_H  = 240;
   localparam int LBL_W  = 6;
   localparam int ADDR_W = 17;
   localparam int XW     = 9;
   localparam int YW     = 8;

   typedef logic [LBL_W-1:0]  label_t;
   typedef logic [XW-1:0]     xpos_t;
   typedef logic [YW-1:0]     ypos_t;
   typedef logic [ADDR_W-1:0] addr_t;

   localparam label_t BG_LABEL  = {LBL_W{1'b0}};
   localparam label_t MAX_LABEL = {LBL_W{1'b1}};
   localparam label_t LBL_ONE   = label_t'(1);
   localparam xpos_t  X_LAST    = xpos_t'(IMG_W - 1);
   localparam ypos_t  Y_LAST    = ypos_t'(IMG_H - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} lab_state_e;

   function automatic label_t label_min(input label_t a, input label_t b);
      return (a < b) ? a : b;
   endfunction

   function automatic label_t label_max(input label_t a, input label_t b);
      return (a < b) ? b : a;
   endfunction
endpackage

// File: rtl/label_line_buffer.sv
// One row of provisional labels: simple dual-port RAM with a registered read
// port and a single write port. Contents are never cleared; row 0 masks them.
module label_line_buffer
   import cc_pkg::*;
#(
   parameter int DEPTH = IMG_W,
   parameter int AW    = XW,
   parameter int DW    = LBL_W
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   // write port and registered read port
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/first_pass_labeler.sv
// First raster pass of the connected-component labeler: assigns provisional
// 4-connected labels, writes the label image and reports equivalence pairs.
module first_pass_labeler
   import cc_pkg::*;
(
   input  logic              iclk,
   input  logic              irst_n,
   input  logic              iSOF,
   input  logic              iVAL,
   input  logic              iPIX,
   output logic              oWrEn,
   output logic [ADDR_W-1:0] oWrAddr,
   output logic [LBL_W-1:0]  oWrData,
   output logic [LBL_W-1:0]  oLabel1,
   output logic [LBL_W-1:0]  oLabel2,
   output logic              oResolve,
   output logic              oLabelingFinish,
   output logic              oOverflow
);

   lab_state_e state_q;
   xpos_t      x_q, x_d, cur_x;
   ypos_t      y_q, y_d, cur_y;
   addr_t      addr_q, addr_d, cur_addr;
   label_t     next_q, next_d, cur_next;
   label_t     up_s, left_s, label_s, rd_data_s;
   xpos_t      rd_addr_s;
   logic       accept_s, new_comp_s, merge_s, last_pix_s, ovf_hit_s;

   logic       wr_en_q, resolve_q, fin_pend_q, finish_q, ovf_q;
   addr_t      wr_addr_q;
   label_t     wr_data_q, lbl1_q, lbl2_q;

   // The next pixel's upper neighbour is prefetched: read x+1 while writing x.
   label_line_buffer u_line_buf (
      .clk_i   (iclk),
      .we_i    (accept_s),
      .waddr_i (cur_x),
      .wdata_i (label_s),
      .raddr_i (rd_addr_s),
      .rdata_o (rd_data_s)
   );

   // label decision for the pixel on the input; iSOF forces the frame origin
   always_comb begin
      accept_s  = iVAL & (iSOF | (state_q == ST_RUN));
      cur_x     = iSOF ? xpos_t'(0) : x_q;
      cur_y     = iSOF ? ypos_t'(0) : y_q;
      cur_addr  = iSOF ? addr_t'(0) : addr_q;
      cur_next  = iSOF ? LBL_ONE    : next_q;

      up_s      = (cur_y != ypos_t'(0)) ? rd_data_s : BG_LABEL;
      left_s    = (cur_x != xpos_t'(0)) ? wr_data_q : BG_LABEL;

      new_comp_s = iPIX & (up_s == BG_LABEL) & (left_s == BG_LABEL);
      merge_s    = iPIX & (up_s != BG_LABEL) & (left_s != BG_LABEL) & (up_s != left_s);
      ovf_hit_s  = new_comp_s & (cur_next == MAX_LABEL);

      if (!iPIX) begin
         label_s = BG_LABEL;
      end else if (new_comp_s) begin
         label_s = cur_next;
      end else if (up_s == BG_LABEL) begin
         label_s = left_s;
      end else if (left_s == BG_LABEL) begin
         label_s = up_s;
      end else begin
         label_s = label_min(up_s, left_s);
      end

      if (new_comp_s && (cur_next != MAX_LABEL)) begin
         next_d = cur_next + LBL_ONE;
      end else begin
         next_d = cur_next;
      end

      last_pix_s = (cur_x == X_LAST) && (cur_y == Y_LAST);
      if (cur_x == X_LAST) begin
         x_d = xpos_t'(0);
         y_d = (cur_y == Y_LAST) ? ypos_t'(0) : cur_y + ypos_t'(1);
      end else begin
         x_d = cur_x + xpos_t'(1);
         y_d = cur_y;
      end
      addr_d    = last_pix_s ? addr_t'(0) : cur_addr + addr_t'(1);
      rd_addr_s = accept_s ? x_d : x_q;
   end

   // frame control, counters and registered outputs
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_q    <= ST_IDLE;
         x_q        <= xpos_t'(0);
         y_q        <= ypos_t'(0);
         addr_q     <= addr_t'(0);
         next_q     <= LBL_ONE;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= addr_t'(0);
         wr_data_q  <= BG_LABEL;
         lbl1_q     <= BG_LABEL;
         lbl2_q     <= BG_LABEL;
         resolve_q  <= 1'b0;
         fin_pend_q <= 1'b0;
         finish_q   <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         wr_en_q    <= accept_s;
         resolve_q  <= accept_s & merge_s;
         fin_pend_q <= accept_s & last_pix_s;
         if (accept_s) begin
            state_q   <= last_pix_s ? ST_DONE : ST_RUN;
            x_q       <= x_d;
            y_q       <= y_d;
            addr_q    <= addr_d;
            next_q    <= next_d;
            wr_addr_q <= cur_addr;
            wr_data_q <= label_s;
            ovf_q     <= (iSOF ? 1'b0 : ovf_q) | ovf_hit_s;
            if (merge_s) begin
               lbl1_q <= label_min(up_s, left_s);
               lbl2_q <= label_max(up_s, left_s);
            end
         end
         // finish follows the last write by one cycle; a new frame clears it
         if (accept_s && iSOF) begin
            finish_q <= 1'b0;
         end else if (fin_pend_q) begin
            finish_q <= 1'b1;
         end
      end
   end

   assign oWrEn           = wr_en_q;
   assign oWrAddr         = wr_addr_q;
   assign oWrData         = wr_data_q;
   assign oLabel1         = lbl1_q;
   assign oLabel2         = lbl2_q;
   assign oResolve        = resolve_q;
   assign oLabelingFinish = finish_q;
   assign oOverflow       = ovf_q;

endmodule

// File: tb/tb_first_pass_labeler.sv
// Self-checking bench for first_pass_labeler: random and directed masks are
// labeled by a whole-image reference model and compared write by write.
module tb_first_pass_labeler;
   localparam int W = 320;
   localparam int H = 240;
   localparam int N = W * H;

   logic        iclk = 1'b0;
   logic        irst_n = 1'b0;
   logic        iSOF = 1'b0, iVAL = 1'b0, iPIX = 1'b0;
   logic        oWrEn, oResolve, oLabelingFinish, oOverflow;
   logic [16:0] oWrAddr;
   logic [5:0]  oWrData, oLabel1, oLabel2;

   int total = 0;
   int bad   = 0;

   bit        mask_m [N];
   byte       lab    [N];
   bit        ovf_m  [N];
   bit [28:0] exp_r  [$];
   bit [23:0] mon_w  [$];
   bit [28:0] mon_r  [$];
   int        cyc = 0;
   int        last_cyc = -1;
   int        fin_cyc  = -1;

   first_pass_labeler dut (
      .iclk(iclk), .irst_n(irst_n), .iSOF(iSOF), .iVAL(iVAL), .iPIX(iPIX),
      .oWrEn(oWrEn), .oWrAddr(oWrAddr), .oWrData(oWrData),
      .oLabel1(oLabel1), .oLabel2(oLabel2), .oResolve(oResolve),
      .oLabelingFinish(oLabelingFinish), .oOverflow(oOverflow)
   );

   always #5 iclk = ~iclk;

   always @(posedge iclk) cyc++;

   always @(negedge iclk) begin
      if (oWrEn) mon_w.push_back({oOverflow, oWrAddr, oWrData});
      if (oResolve) mon_r.push_back({oLabel1, oLabel2, oWrAddr});
      if (oWrEn && oWrAddr == 17'd76799) last_cyc = cyc;
      if (oLabelingFinish && fin_cyc < 0) fin_cyc = cyc;
   end

   // Reference: label every pixel of the image from its already-labeled
   // upper and left neighbours in the 2-D label array.
   task automatic model(input int n);
      int nl, up, lf, mn, mx;
      bit ov;
      exp_r.delete();
      nl = 1;
      ov = 1'b0;
      for (int i = 0; i < n; i++) begin
         up = (i / W > 0) ? int'(lab[i - W]) : 0;
         lf = (i % W > 0) ? int'(lab[i - 1]) : 0;
         mn = (up < lf) ? up : lf;
         mx = (up < lf) ? lf : up;
         if (!mask_m[i]) lab[i] = 8'd0;
         else if (up == 0 && lf == 0) begin
            lab[i] = 8'(nl);
            if (nl == 63) ov = 1'b1; else nl++;
         end
         else if (up == 0) lab[i] = 8'(lf);
         else if (lf == 0) lab[i] = 8'(up);
         else begin
            lab[i] = 8'(mn);
            if (up != lf) exp_r.push_back({6'(mn), 6'(mx), 17'(i)});
         end
         ovf_m[i] = ov;
      end
   endtask

   task automatic set_mask(input int n, input int dens_pct);
      for (int i = 0; i < N; i++)
         mask_m[i] = (i < n) && ($urandom_range(0, 99) < dens_pct);
   endtask

   task automatic feed(input int n, input int gap_pct);
      mon_w.delete();
      mon_r.delete();
      for (int i = 0; i < n; i++) begin
         while ($urandom_range(0, 99) < gap_pct) begin
            @(negedge iclk);
            iVAL = 1'b0; iSOF = 1'b0; iPIX = 1'($urandom);
         end
         @(negedge iclk);
         iVAL = 1'b1; iSOF = (i == 0); iPIX = mask_m[i];
      end
      @(negedge iclk);
      iVAL = 1'b0; iSOF = 1'b0; iPIX = 1'b0;
      repeat (3) @(negedge iclk);
   endtask

   task automatic test_reset;
      irst_n = 1'b0;
      repeat (3) @(negedge iclk);
      total++;
      if ({oWrEn, oWrAddr, oWrData, oLabel1, oLabel2, oResolve, oLabelingFinish, oOverflow} !== 38'd0) begin
         bad++; $display("FAIL reset_outputs got=%h want=0", {oWrEn, oWrAddr, oWrData, oLabel1, oLabel2, oResolve, oLabelingFinish, oOverflow});
      end
      irst_n = 1'b1;
      mon_w.delete();
      @(negedge iclk);
      iVAL = 1'b1; iPIX = 1'b1;
      repeat (10) @(negedge iclk);
      iVAL = 1'b0; iPIX = 1'b0;
      repeat (2) @(negedge iclk);
      total++;
      if (mon_w.size() !== 0) begin
         bad++; $display("FAIL prestart_ignored got=%0d writes want=0", mon_w.size());
      end
   endtask

   task automatic test_square;
      set_mask(0, 0);
      for (int y = 5; y <= 7; y++) for (int x = 10; x <= 12; x++) mask_m[y * W + x] = 1'b1;
      model(8 * W);
      feed(8 * W, 10);
      total++;
      if (mon_w.size() !== 8 * W) begin bad++; $display("FAIL square_count got=%0d want=%0d", mon_w.size(), 8 * W); end
      for (int i = 0; i < mon_w.size() && i < 8 * W; i++) begin
         total++;
         if (mon_w[i] !== {ovf_m[i], 17'(i), 6'(lab[i])}) begin
            bad++; if (bad < 20) $display("FAIL square_wr[%0d] got=%h want=%h", i, mon_w[i], {ovf_m[i], 17'(i), 6'(lab[i])});
         end
      end
      total++;
      if (mon_w[6 * W + 11][5:0] !== 6'd1 || mon_r.size() !== 0) begin
         bad++; $display("FAIL square_label got=%0d resolves=%0d want=1/0", mon_w[6 * W + 11][5:0], mon_r.size());
      end
   endtask

   task automatic test_u_shape;
      set_mask(0, 0);
      for (int y = 0; y <= 3; y++) begin mask_m[y * W + 2] = 1'b1; mask_m[y * W + 6] = 1'b1; end
      for (int x = 2; x <= 6; x++) mask_m[4 * W + x] = 1'b1;
      model(5 * W);
      feed(5 * W, 15);
      total++;
      if (mon_r.size() !== 1 || mon_r[0] !== {6'd1, 6'd2, 17'(4 * W + 6)}) begin
         bad++; $display("FAIL u_resolve got=%0d pairs first=%h want=1 pair %h", mon_r.size(), (mon_r.size() > 0) ? mon_r[0] : 29'd0, {6'd1, 6'd2, 17'(4 * W + 6)});
      end
      for (int i = 0; i < mon_w.size() && i < 5 * W; i++) begin
         total++;
         if (mon_w[i] !== {ovf_m[i], 17'(i), 6'(lab[i])}) begin
            bad++; if (bad < 20) $display("FAIL u_wr[%0d] got=%h want=%h", i, mon_w[i], {ovf_m[i], 17'(i), 6'(lab[i])});
         end
      end
   endtask

   task automatic test_overflow;
      set_mask(0, 0);
      for (int k = 0; k < 70; k++) mask_m[2 * k] = 1'b1;
      model(W);
      feed(W, 0);
      total++;
      if (mon_w.size() !== W) begin bad++; $display("FAIL ovf_count got=%0d want=%0d", mon_w.size(), W); end
      for (int i = 0; i < mon_w.size() && i < W; i++) begin
         total++;
         if (mon_w[i] !== {ovf_m[i], 17'(i), 6'(lab[i])}) begin
            bad++; if (bad < 20) $display("FAIL ovf_wr[%0d] got=%h want=%h", i, mon_w[i], {ovf_m[i], 17'(i), 6'(lab[i])});
         end
      end
      total++;
      if (mon_w[122][23] !== 1'b0 || mon_w[124] !== {1'b1, 17'd124, 6'd63} || mon_w[138][5:0] !== 6'd63) begin
         bad++; $display("FAIL ovf_edge got=%h %h %h want ovf rising at x=124 with label 63", mon_w[122], mon_w[124], mon_w[138]);
      end
   endtask

   task automatic test_random;
      for (int it = 0; it < 3; it++) begin
         set_mask(3 * W, 40);
         model(3 * W);
         feed(3 * W, 20);
         total++;
         if (mon_w.size() !== 3 * W || mon_r.size() !== exp_r.size()) begin
            bad++; $display("FAIL rand_counts got=%0d/%0d want=%0d/%0d", mon_w.size(), mon_r.size(), 3 * W, exp_r.size());
         end
         for (int i = 0; i < mon_w.size() && i < 3 * W; i++) begin
            total++;
            if (mon_w[i] !== {ovf_m[i], 17'(i), 6'(lab[i])}) begin
               bad++; if (bad < 20) $display("FAIL rand_wr[%0d] got=%h want=%h", i, mon_w[i], {ovf_m[i], 17'(i), 6'(lab[i])});
            end
         end
         for (int i = 0; i < mon_r.size() && i < exp_r.size(); i++) begin
            total++;
            if (mon_r[i] !== exp_r[i]) begin
               bad++; if (bad < 20) $display("FAIL rand_pair[%0d] got=%h want=%h", i, mon_r[i], exp_r[i]);
            end
         end
      end
   endtask

   task automatic test_sof_abort;
      set_mask(1000, 50);
      feed(1000, 5);
      set_mask(2 * W, 30);
      mask_m[0] = 1'b1;
      model(2 * W);
      feed(2 * W, 5);
      total++;
      if (mon_w.size() < 1 || mon_w[0] !== {1'b0, 17'd0, 6'd1}) begin
         bad++; $display("FAIL abort_first got=%h want=%h", (mon_w.size() > 0) ? mon_w[0] : 24'd0, {1'b0, 17'd0, 6'd1});
      end
      for (int i = 0; i < mon_w.size() && i < 2 * W; i++) begin
         total++;
         if (mon_w[i] !== {ovf_m[i], 17'(i), 6'(lab[i])}) begin
            bad++; if (bad < 20) $display("FAIL abort_wr[%0d] got=%h want=%h", i, mon_w[i], {ovf_m[i], 17'(i), 6'(lab[i])});
         end
      end
   endtask

   task automatic test_back_to_back;
      set_mask(3 * W, 20);
      model(N);
      last_cyc = -1;
      fin_cyc  = -1;
      feed(N, 0);
      total++;
      if (mon_w.size() !== N || mon_r.size() !== exp_r.size()) begin
         bad++; $display("FAIL full_counts got=%0d/%0d want=%0d/%0d", mon_w.size(), mon_r.size(), N, exp_r.size());
      end
      for (int i = 0; i < mon_w.size() && i < N; i++) begin
         total++;
         if (mon_w[i] !== {ovf_m[i], 17'(i), 6'(lab[i])}) begin
            bad++; if (bad < 20) $display("FAIL full_wr[%0d] got=%h want=%h", i, mon_w[i], {ovf_m[i], 17'(i), 6'(lab[i])});
         end
      end
      total++;
      if (last_cyc < 0 || fin_cyc !== last_cyc + 1) begin
         bad++; $display("FAIL finish_timing got=%0d want=%0d", fin_cyc, last_cyc + 1);
      end
      mon_w.delete();
      iVAL = 1'b1; iPIX = 1'b1;
      repeat (10) @(negedge iclk);
      iVAL = 1'b0; iPIX = 1'b0;
      repeat (2) @(negedge iclk);
      total++;
      if (mon_w.size() !== 0 || oLabelingFinish !== 1'b1) begin
         bad++; $display("FAIL finished_ignore got=%0d writes fin=%b want=0 writes fin=1", mon_w.size(), oLabelingFinish);
      end
      set_mask(W, 30);
      model(W);
      feed(W, 0);
      total++;
      if (oLabelingFinish !== 1'b0 || mon_w.size() !== W || mon_w[W - 1] !== {ovf_m[W - 1], 17'(W - 1), 6'(lab[W - 1])}) begin
         bad++; $display("FAIL restart_after_finish fin=%b writes=%0d want fin=0 writes=%0d", oLabelingFinish, mon_w.size(), W);
      end
   endtask

   task automatic test_reset_mid;
      set_mask(2 * W, 60);
      feed(500, 30);
      @(negedge iclk);
      iVAL = 1'b1; iPIX = 1'b1;
      irst_n = 1'b0;
      #1;
      total++;
      if ({oWrEn, oWrAddr, oWrData, oLabel1, oLabel2, oResolve, oLabelingFinish, oOverflow} !== 38'd0) begin
         bad++; $display("FAIL reset_mid_outputs got=%h want=0", {oWrEn, oWrAddr, oWrData, oLabel1, oLabel2, oResolve, oLabelingFinish, oOverflow});
      end
      repeat (3) @(negedge iclk);
      irst_n = 1'b1;
      mon_w.delete();
      repeat (20) @(negedge iclk);
      iVAL = 1'b0;
      @(negedge iclk);
      total++;
      if (mon_w.size() !== 0) begin
         bad++; $display("FAIL post_reset_ignored got=%0d writes want=0", mon_w.size());
      end
      mask_m[0] = 1'b1;
      model(2 * W);
      feed(2 * W, 25);
      total++;
      if (mon_w.size() !== 2 * W || mon_w[0] !== {1'b0, 17'd0, 6'd1}) begin
         bad++; $display("FAIL post_reset_frame got=%0d writes first=%h want=%0d first=%h", mon_w.size(), (mon_w.size() > 0) ? mon_w[0] : 24'd0, 2 * W, {1'b0, 17'd0, 6'd1});
      end
      for (int i = 0; i < mon_w.size() && i < 2 * W; i++) begin
         total++;
         if (mon_w[i] !== {ovf_m[i], 17'(i), 6'(lab[i])}) begin
            bad++; if (bad < 20) $display("FAIL post_reset_wr[%0d] got=%h want=%h", i, mon_w[i], {ovf_m[i], 17'(i), 6'(lab[i])});
         end
      end
   endtask

   initial begin
      test_reset();
      test_square();
      test_u_shape();
      test_overflow();
      test_random();
      test_sof_abort();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
